// File: rtl/voq_out_module_pkg.sv
// Shared widths and types for the VOQ egress module and its payload FIFO.
package voq_out_module_pkg;

    localparam int unsigned PORT_NUB_TOTAL  = 4;
    localparam int unsigned DATA_WIDTH      = 8;
    localparam int unsigned DATA_LENGTH_MAX = 16;

    localparam int unsigned PORT_NUB     = PORT_NUB_TOTAL;
    localparam int unsigned WIDTH_SEL    = $clog2(PORT_NUB);
    localparam int unsigned WIDTH_PORT   = WIDTH_SEL + DATA_WIDTH;
    localparam int unsigned WIDTH_LENGTH = $clog2(DATA_LENGTH_MAX);

    // Frame FSM: header expected, payload streaming, release cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One FIFO entry: framing flags plus payload word.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/voq_out_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on dout while not empty.
module voq_out_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/voq_out_module.sv
// Egress port: strips the frame header, buffers payload and pulses a release to the source.
module voq_out_module
    import voq_out_module_pkg::*;
#(
    parameter int unsigned NUB        = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid_in,
    input  logic [WIDTH_PORT-1:0] mem_data_in,
    output logic                  mem_ready_out,
    input  logic                  port_ready_in,
    output logic                  port_valid_out,
    output logic [DATA_WIDTH-1:0] port_data_out,
    output logic                  port_sop_out,
    output logic                  port_eop_out,
    output logic [PORT_NUB-1:0]   done_out,
    output logic                  err_out
);

    if (NUB >= PORT_NUB) begin : g_nub_check
        $error("voq_out_module: NUB must be below PORT_NUB");
    end

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH_SEL-1:0]    src;
    logic [WIDTH_LENGTH-1:0] rem;
    logic                    first;

    logic                    accept;
    logic                    last;
    logic                    src_valid;
    logic [WIDTH_SEL-1:0]    hdr_sel;
    logic [DATA_WIDTH-1:0]   word;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    fifo_word_t              fifo_din;
    fifo_word_t              fifo_dout;
    logic                    unused_hdr_bits;

    assign hdr_sel         = mem_data_in[WIDTH_PORT-1 -: WIDTH_SEL];
    assign word            = mem_data_in[DATA_WIDTH-1:0];
    assign unused_hdr_bits = ^word[DATA_WIDTH-1:WIDTH_LENGTH];
    assign accept          = mem_valid_in && mem_ready_out;
    assign last            = (rem == '0);
    assign src_valid       = 32'(src) < PORT_NUB;

    assign push     = accept && (state == ST_BODY);
    assign fifo_din = '{sop: first, eop: last, data: word};
    assign pop      = port_valid_out && port_ready_in;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state: header -> payload until eop -> single release cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_BODY;
            ST_BODY: if (accept && last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state and FIFO occupancy only.
    always_comb begin
        mem_ready_out = (state != ST_DONE) && !fifo_full;
        done_out      = '0;
        err_out       = 1'b0;
        if (state == ST_DONE) begin
            if (src_valid) done_out[src] = 1'b1;
            else           err_out       = 1'b1;
        end
    end

    // Frame bookkeeping: source, remaining-word count and first-word flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src   <= '0;
            rem   <= '0;
            first <= 1'b0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                src   <= hdr_sel;
                rem   <= word[WIDTH_LENGTH-1:0];
                first <= 1'b1;
            end else if (state == ST_BODY) begin
                first <= 1'b0;
                if (!last) rem <= rem - WIDTH_LENGTH'(1);
            end
        end
    end

    voq_out_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign port_valid_out = !fifo_empty;
    assign port_data_out  = fifo_dout.data;
    assign port_sop_out   = fifo_dout.sop;
    assign port_eop_out   = fifo_dout.eop;

endmodule
